// File: rtl/sequence_adder.sv
// 8-bit running-sum accumulator: Q <= Q + A (mod 256) on every rising CLK edge.
// Latency: one clock from A sampled at an edge to Q; synchronous active-high reset wins.
// Backpressure: none. There is no handshake, so every edge accumulates.
module sequence_adder (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] A,
    output logic [7:0] Q
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;

    // Ripple-carry adder built from eight full-adder stages with carry-in 0.
    // The carry out of bit 7 is computed but intentionally dropped (modulo 2^8).
    always_comb begin
        logic carry;
        carry = 1'b0;
        acc_d = '0;
        for (int i = 0; i < 8; i++) begin
            acc_d[i] = acc_q[i] ^ A[i] ^ carry;
            carry    = (acc_q[i] & A[i]) | (carry & (acc_q[i] ^ A[i]));
        end
    end

    // Accumulator register; reset is sampled only at the clock edge and overrides A.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_q <= 8'h00;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign Q = acc_q;

endmodule

// File: tb/tb_sequence_adder.sv
// Self-checking bench for sequence_adder: directed steps followed by random stimulus.
// Reference model is a plain modulo-256 running sum kept as an integer.
// Inputs change 1 time unit after each rising edge; Q is checked at the same point.
module tb_sequence_adder;

    logic       CLK;
    logic       RST;
    logic [7:0] A;
    logic [7:0] Q;

    int checks   = 0;
    int failures = 0;
    int unsigned model_q = 0;

    sequence_adder dut (
        .CLK (CLK),
        .RST (RST),
        .A   (A),
        .Q   (Q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one edge's worth of inputs, let the edge happen, then compare to the model.
    task automatic step(input logic rst, input logic [7:0] a, input string tag,
                        input bit do_check, input logic [7:0] want);
        RST = rst;
        A   = a;
        @(posedge CLK);
        #1;
        if (rst) model_q = 0;
        else     model_q = (model_q + a) % 256;
        check({tag, "_model"}, Q, model_q[7:0]);
        if (do_check) check(tag, Q, want);
    endtask

    initial begin
        logic [7:0] held;
        RST = 1'b0;
        A   = 8'h00;
        @(posedge CLK);
        #1;

        // Reset then a power-of-two sequence
        step(1'b1, 8'h5A, "reset",    1, 8'h00);
        step(1'b0, 8'h01, "seq_01",   1, 8'h01);
        step(1'b0, 8'h02, "seq_03",   1, 8'h03);
        step(1'b0, 8'h04, "seq_07",   1, 8'h07);
        step(1'b0, 8'h08, "seq_0f",   1, 8'h0F);

        // Reset beats a simultaneous add
        step(1'b1, 8'h10, "rst_wins", 1, 8'h00);

        // Restart after reset
        step(1'b0, 8'h20, "rs_20",    1, 8'h20);
        step(1'b0, 8'h40, "rs_60",    1, 8'h60);
        step(1'b0, 8'h80, "rs_e0",    1, 8'hE0);

        // Wrap-around
        step(1'b0, 8'h30, "wrap_10",  1, 8'h10);
        step(1'b1, 8'h00, "rst2",     1, 8'h00);
        step(1'b0, 8'hFF, "to_ff",    1, 8'hFF);
        step(1'b0, 8'h01, "wrap_00",  1, 8'h00);

        // Reset pulse entirely between edges has no effect
        step(1'b0, 8'h07, "pre_pulse", 1, 8'h07);
        held = Q;
        RST = 1'b1;
        #2;
        check("pulse_hi", Q, held);
        RST = 1'b0;
        #2;
        check("pulse_lo", Q, held);
        step(1'b0, 8'h05, "post_pulse", 1, 8'h0C);

        // Hold with A = 0 over three edges
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, "hold", 1, 8'h0C);

        // A toggled between edges; only the value present at the edge counts
        A = 8'h11;
        #1;
        check("toggle_a", Q, 8'h0C);
        A = 8'h22;
        #1;
        check("toggle_b", Q, 8'h0C);
        A = 8'h33;
        #1;
        check("toggle_c", Q, 8'h0C);
        step(1'b0, 8'h44, "toggle_edge", 1, 8'h50);

        // Random traffic with occasional resets, checked against the model only
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)), "rand", 0, 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
